// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and ALU function constants plus the packed control word shared by decoder and ALU.
package cpu_pkg;
    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [2:0] ALU_FWD  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    typedef struct packed {
        logic       reg_write_enable;
        logic       negate;
        logic       alu_source;
        logic [2:0] aluop;
    } ctrl_t;
    localparam ctrl_t CTRL_NOP = '{reg_write_enable: 1'b0, negate: 1'b0, alu_source: 1'b0, aluop: ALU_FWD};
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode to control-word decode.
//   opcode_i  in  8  full opcode, all bits compared
//   ctrl_o    out    control word; unknown opcodes decode to NOP
module control_decode
    import cpu_pkg::*;
(
    input  logic [7:0] opcode_i,
    output ctrl_t      ctrl_o
);
    always_comb begin
        ctrl_o = CTRL_NOP;
        case (opcode_i)
            OP_LOADI: ctrl_o = '{reg_write_enable: 1'b1, negate: 1'b0, alu_source: 1'b1, aluop: ALU_FWD};
            OP_MOV:   ctrl_o = '{reg_write_enable: 1'b1, negate: 1'b0, alu_source: 1'b0, aluop: ALU_FWD};
            OP_ADD:   ctrl_o = '{reg_write_enable: 1'b1, negate: 1'b0, alu_source: 1'b0, aluop: ALU_ADD};
            // subtract is an ADD of the two's-complement negated operand
            OP_SUB:   ctrl_o = '{reg_write_enable: 1'b1, negate: 1'b1, alu_source: 1'b0, aluop: ALU_ADD};
            OP_AND:   ctrl_o = '{reg_write_enable: 1'b1, negate: 1'b0, alu_source: 1'b0, aluop: ALU_AND};
            OP_OR:    ctrl_o = '{reg_write_enable: 1'b1, negate: 1'b0, alu_source: 1'b0, aluop: ALU_OR};
            default:  ctrl_o = CTRL_NOP;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: registered instruction decoder for the 8-bit single-cycle processor.
//   CLK             in   1  processor clock, rising edge
//   RESET           in   1  asynchronous active-low reset, clears all outputs
//   opcode          in   8  instruction opcode field
//   regWriteEnable  out  1  write ALU result to destination register
//   negate          out  1  negate operand 2 before the ALU
//   aluSource       out  1  1 = immediate operand, 0 = register operand 2
//   aluop           out  3  ALU function code
module control_unit
    import cpu_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] opcode,
    output logic       regWriteEnable,
    output logic       negate,
    output logic       aluSource,
    output logic [2:0] aluop
);
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    control_decode u_decode (
        .opcode_i (opcode),
        .ctrl_o   (ctrl_d)
    );
    // one register for the whole word so all outputs change on the same edge
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) ctrl_q <= CTRL_NOP;
        else        ctrl_q <= ctrl_d;
    end
    assign regWriteEnable = ctrl_q.reg_write_enable;
    assign negate         = ctrl_q.negate;
    assign aluSource      = ctrl_q.alu_source;
    assign aluop          = ctrl_q.aluop;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit with a table-driven reference decode.
module tb_control_unit;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] opcode = 8'h02;
    logic       regWriteEnable;
    logic       negate;
    logic       aluSource;
    logic [2:0] aluop;
    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];
    logic [5:0] legal_tbl [6];

    control_unit dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .opcode         (opcode),
        .regWriteEnable (regWriteEnable),
        .negate         (negate),
        .aluSource      (aluSource),
        .aluop          (aluop)
    );

    always #5 CLK = ~CLK;

    // expected word {aluop, aluSource, negate, regWriteEnable}
    function automatic logic [5:0] ref_model(input logic [7:0] op, input logic rst_n);
        if (!rst_n) return 6'b000000;
        if (op < 8'd6) return legal_tbl[op[2:0]];
        return 6'b000000;
    endfunction

    function automatic logic [5:0] got();
        return {aluop, aluSource, negate, regWriteEnable};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got aluop/src/neg/we=%b_%b_%b_%b expected %b_%b_%b_%b",
                     name, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // drive before the next rising edge and record what that edge must produce
    task automatic step(input logic [7:0] op, input logic rst_n);
        @(negedge CLK);
        opcode = op;
        RESET  = rst_n;
        exp_q.push_back(ref_model(op, rst_n));
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) check("scoreboard", got(), exp_q.pop_front());
        end
    end

    initial begin
        legal_tbl[0] = 6'b000_1_0_1;
        legal_tbl[1] = 6'b000_0_0_1;
        legal_tbl[2] = 6'b001_0_0_1;
        legal_tbl[3] = 6'b001_0_1_1;
        legal_tbl[4] = 6'b010_0_0_1;
        legal_tbl[5] = 6'b011_0_0_1;
        #2 RESET = 1'b0;
        #1 check("reset_async", got(), 6'b0);
        for (int i = 0; i < 4; i++) step(8'h02, 1'b0);
        for (int i = 0; i < 6; i++) step(8'(i), 1'b1);
        step(8'h06, 1'b1);
        step(8'h7F, 1'b1);
        step(8'h82, 1'b1);
        step(8'hFF, 1'b1);
        step(8'h01, 1'b1);
        @(posedge CLK);
        #2 opcode = 8'h03;
        #1 check("latency_hold_mov", got(), 6'b000_0_0_1);
        step(8'h03, 1'b1);
        step(8'h03, 1'b1);
        step(8'h04, 1'b1);
        @(posedge CLK);
        #3 RESET = 1'b0;
        #1 check("reset_mid_cycle", got(), 6'b0);
        step(8'h02, 1'b0);
        step(8'h02, 1'b0);
        step(8'h00, 1'b1);
        #1 check("reset_release_wait", got(), 6'b0);
        for (int i = 0; i < 300; i++) begin
            logic [7:0] op;
            op = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            step(op, ($urandom_range(0, 19) != 0));
        end
        step(8'h05, 1'b1);
        @(posedge CLK);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words left, 0 required", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
